microwave_timer_ctrl: RTL
=========================

# microwave_timer_ctrl

Sequencing controller for the microwave countdown timer. It collects keypad digits into an mm:ss preset, loads the preset into the seconds/tens/minutes counter chain, and gates the chain's count enable from the 1 Hz tick. It handles start, stop and door interlock, and drives the magnetron enable and end-of-cook beep. It sits between the keypad/button front end and the counter chain.

## Interface
- BEEP_TICKS, default 3: number of tick pulses the beep output stays high in DONE (1..15).
- clk  in  1  system clock, all state on rising edge
- clear  in  1  asynchronous reset, active-high
- tick  in  1  one-cycle 1 Hz strobe, synchronous to clk
- key_valid  in  1  one-cycle strobe: key_digit is valid
- key_digit  in  4  BCD digit from keypad
- start  in  1  start/resume request (level, sampled each cycle)
- stop  in  1  pause/cancel request (level, sampled each cycle)
- door_closed  in  1  1 = door closed
- time_zero  in  1  AND of all counter-chain zero flags
- loadn  out  1  active-low load strobe to the counter chain
- data  out  16  preset to counter chain: [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units
- en  out  1  count enable to the counter chain
- magnetron_on  out  1  heating enable
- beep  out  1  end-of-cook buzzer
- state  out  3  current state code: IDLE=0, ENTRY=1, LOAD=2, RUN=3, PAUSE=4, DONE=5

## Operation
- Entry register ent[15:0] and digit count cnt[2:0]. The data output equals ent at all times.
- Valid key in IDLE or ENTRY: ent <= {ent[11:0], key_digit}, cnt <= cnt+1. Ignored when key_digit > 9 or cnt == 4.
- Input priority each cycle: stop > door open > start > key.
- IDLE:
  - Valid key -> ENTRY.
  - start is ignored.
- ENTRY:
  - stop -> IDLE, ent = 0, cnt = 0.
  - start & door_closed & ent != 0 -> LOAD.
  - Otherwise stay.
- LOAD: lasts exactly one cycle, with loadn = 0. Next state is RUN.
- RUN:
  - magnetron_on = 1.
  - en = tick & ~time_zero & door_closed & ~stop.
  - stop or ~door_closed -> PAUSE.
  - Else time_zero -> DONE.
- PAUSE:
  - en = 0, magnetron_on = 0.
  - stop -> IDLE, clearing ent and cnt.
  - start & door_closed -> RUN. No reload; the counters keep their value.
- DONE:
  - beep = 1. A beep counter is loaded with BEEP_TICKS on entry and decrements on each tick.
  - Leave to IDLE when the counter reaches 0, or on stop, or on a valid key. The key is not captured.
  - ent and cnt are cleared on exit.
- Preset values with seconds-tens > 5 are passed unchanged; the counter chain normalises them.
- Out-of-range state encodings (6, 7) -> IDLE on the next edge.

## Timing
- Reset values:
  - state = IDLE, ent = 0, cnt = 0, beep counter = 0.
  - loadn = 1, data = 0, en = 0, magnetron_on = 0, beep = 0.
- loadn, magnetron_on, beep and state are Moore outputs decoded from the registered state. They are glitch-free relative to clk.
- en is combinational from state and inputs. It is high only in the same cycle as an accepted tick.
- Start-to-count latency:
  - Start sampled at edge N in ENTRY -> LOAD during cycle N+1 (counters load at edge N+2) -> RUN from N+2.
  - The first decrement happens on the first tick at or after cycle N+2.
- A tick coinciding with a door-open or stop cycle produces no decrement.
- A tick coinciding with time_zero produces no en; the controller goes to DONE.
- Keys arriving in LOAD, RUN or PAUSE are ignored.
- clear asserted mid-operation forces all reset values immediately, asynchronously. Normal operation resumes on the first edge after deassertion.

## Test plan
- Keys 1,3,0 then start with door_closed -> data = 0x0130; loadn low exactly one cycle; state goes 1->2->3; magnetron_on = 1 from the RUN cycle.
- Keys 1,2,3,4,5 -> fifth key ignored, data = 0x1234. Key digit 0xA -> ignored, cnt unchanged.
- In RUN, door opens on a tick cycle -> en = 0 that cycle, state = 4, magnetron_on = 0. Then start with door closed -> state = 3, no loadn pulse.
- In RUN, assert time_zero -> next state = 5, beep = 1 for exactly 3 ticks (default), then state = 0, data = 0.
- Start in IDLE or with ent = 0 -> state unchanged, loadn stays 1. stop in ENTRY -> IDLE, data = 0.
- Assert clear during RUN -> same cycle: en = 0, magnetron_on = 0, loadn = 1, state = 0.

Source files
------------

// File: rtl/microwave_timer_ctrl.sv
// Sequencing controller for the microwave countdown timer.
// Collects keypad digits into an mm:ss preset, loads it into the counter
// chain, gates the chain's count enable from the 1 Hz tick, and drives the
// magnetron enable and the end-of-cook beep.
//
// Ports:
//   clk          system clock, all state on rising edge
//   clear        asynchronous reset, active-high
//   tick         one-cycle 1 Hz strobe
//   key_valid    one-cycle strobe qualifying key_digit
//   key_digit    BCD digit from keypad
//   start        start/resume request (level)
//   stop         pause/cancel request (level)
//   door_closed  1 = door closed
//   time_zero    all counter-chain digits are zero
//   loadn        active-low load strobe to the counter chain (registered)
//   data         preset to the counter chain, mm:ss in BCD (registered)
//   en           count enable to the counter chain (combinational)
//   magnetron_on heating enable (registered)
//   beep         end-of-cook buzzer (registered)
//   state        current state code (registered)
module microwave_timer_ctrl #(
  parameter int unsigned BEEP_TICKS = 3
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        tick,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        door_closed,
  input  logic        time_zero,
  output logic        loadn,
  output logic [15:0] data,
  output logic        en,
  output logic        magnetron_on,
  output logic        beep,
  output logic [2:0]  state
);

  localparam int unsigned ENT_W      = 16;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned BCNT_W     = 4;
  localparam int unsigned MAX_DIGITS = 4;

  localparam logic [3:0] MAX_BCD = 4'd9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [ENT_W-1:0]  ent_q, ent_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [BCNT_W-1:0] bcnt_q, bcnt_nxt;
  logic [2:0]        state_nxt;
  logic              key_ok;

  // A digit is accepted only if it is BCD and the preset is not yet full.
  assign key_ok = key_valid && (key_digit <= MAX_BCD) &&
                  (cnt_q != CNT_W'(MAX_DIGITS));

  assign data = ent_q;

  // Next-state, entry-register and count-enable decode.
  always_comb begin
    state_nxt = state;
    ent_nxt   = ent_q;
    cnt_nxt   = cnt_q;
    bcnt_nxt  = bcnt_q;
    en        = 1'b0;

    case (state)
      S_IDLE: begin
        if (!stop && key_ok) begin
          ent_nxt   = {ent_q[ENT_W-5:0], key_digit};
          cnt_nxt   = cnt_q + CNT_W'(1);
          state_nxt = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (stop) begin
          ent_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (start && door_closed && (ent_q != '0)) begin
          state_nxt = S_LOAD;
        end else if (key_ok) begin
          ent_nxt = {ent_q[ENT_W-5:0], key_digit};
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      S_LOAD: begin
        state_nxt = S_RUN;
      end

      S_RUN: begin
        // Never count on a cycle that is about to leave RUN.
        en = tick && !time_zero && door_closed && !stop;
        if (stop || !door_closed) begin
          state_nxt = S_PAUSE;
        end else if (time_zero) begin
          bcnt_nxt  = BCNT_W'(BEEP_TICKS);
          state_nxt = S_DONE;
        end
      end

      S_PAUSE: begin
        if (stop) begin
          ent_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (start && door_closed) begin
          state_nxt = S_RUN;
        end
      end

      S_DONE: begin
        // Any key just silences the beep; the digit is not captured.
        if (stop || key_valid || (bcnt_q == '0)) begin
          ent_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (tick) begin
          bcnt_nxt = bcnt_q - BCNT_W'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and Moore outputs, decoded from the next state so they are
  // registered and aligned with the state code.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state        <= S_IDLE;
      ent_q        <= '0;
      cnt_q        <= '0;
      bcnt_q       <= '0;
      loadn        <= 1'b1;
      magnetron_on <= 1'b0;
      beep         <= 1'b0;
    end else begin
      state        <= state_nxt;
      ent_q        <= ent_nxt;
      cnt_q        <= cnt_nxt;
      bcnt_q       <= bcnt_nxt;
      loadn        <= (state_nxt != S_LOAD);
      magnetron_on <= (state_nxt == S_RUN);
      beep         <= (state_nxt == S_DONE);
    end
  end

endmodule
